// File: rtl/sublist_sorted_store.sv
// Sorted scheduler sublist: keeps up to N elements ordered by rank, inserts in two
// cycles, pops the head in one, and publishes a registered pointer summary.
package vertigo_datatypes;
  localparam int NUM_OF_ELEMENTS_PER_SUBLIST = 8;
  localparam int NUM_OF_SUBLIST              = 16;

  typedef struct packed {
    logic [5:0]  id;
    logic [15:0] rank;
    logic [15:0] send_time;
  } SublistElement;

  typedef struct packed {
    logic [3:0]  id;
    logic [15:0] smallest_rank;
    logic [15:0] smallest_send_time;
    logic        full;
    logic [2:0]  num;
  } PointerElement;
endpackage

module sublist_sorted_store
  import vertigo_datatypes::*;
#(
  parameter int NUM_OF_SUBLIST_ELEMS = NUM_OF_ELEMENTS_PER_SUBLIST,
  parameter int SUBLIST_IDX_W        = $clog2(NUM_OF_SUBLIST)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SUBLIST_IDX_W-1:0] sublist_id,
  input  logic                     ins_valid,
  output logic                     ins_ready,
  input  SublistElement            ins_elem,
  input  logic                     pop_valid,
  output logic                     pop_ready,
  output SublistElement            pop_elem,
  output logic                     pop_elem_valid,
  output PointerElement            ptr_out
);

  localparam int N     = NUM_OF_SUBLIST_ELEMS;
  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic {IDLE, INS} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  SublistElement    entries_q [N];
  SublistElement    entries_d [N];
  SublistElement    latch_q, latch_d;
  SublistElement    pop_elem_q, pop_elem_d;
  logic             pop_elem_valid_q, pop_elem_valid_d;
  PointerElement    ptr_q, ptr_d;
  logic [CNT_W-1:0] ins_idx;
  logic [15:0]      min_send_time;

  // Entries are sorted, so counting ranks <= the new rank gives the FIFO-stable slot.
  always_comb begin
    ins_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (CNT_W'(i) < count_q && entries_q[i].rank <= latch_q.rank) begin
        ins_idx = ins_idx + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    entries_d        = entries_q;
    latch_d          = latch_q;
    pop_elem_d       = pop_elem_q;
    pop_elem_valid_d = 1'b0;
    ins_ready        = 1'b0;
    pop_ready        = 1'b0;

    case (state_q)
      IDLE: begin
        pop_ready = (count_q != '0);
        ins_ready = (count_q != CNT_W'(N)) && !pop_valid;
        if (pop_valid && pop_ready) begin
          pop_elem_d       = entries_q[0];
          pop_elem_valid_d = 1'b1;
          for (int i = 0; i < N - 1; i++) begin
            entries_d[i] = entries_q[i+1];
          end
          count_d = count_q - CNT_W'(1);
        end else if (ins_valid && ins_ready) begin
          latch_d = ins_elem;
          state_d = INS;
        end
      end
      INS: begin
        for (int i = 1; i < N; i++) begin
          if (CNT_W'(i) > ins_idx && CNT_W'(i) <= count_q) begin
            entries_d[i] = entries_q[i-1];
          end
        end
        for (int i = 0; i < N; i++) begin
          if (CNT_W'(i) == ins_idx) begin
            entries_d[i] = latch_q;
          end
        end
        count_d = count_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    min_send_time = 16'hFFFF;
    for (int i = 0; i < N; i++) begin
      if (CNT_W'(i) < count_q && entries_q[i].send_time < min_send_time) begin
        min_send_time = entries_q[i].send_time;
      end
    end
    ptr_d.id                 = 4'(sublist_id);
    ptr_d.smallest_rank      = (count_q != '0) ? entries_q[0].rank : 16'hFFFF;
    ptr_d.smallest_send_time = min_send_time;
    ptr_d.full               = (count_q == CNT_W'(N));
    ptr_d.num                = 3'(count_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      count_q          <= '0;
      latch_q          <= '0;
      pop_elem_q       <= '0;
      pop_elem_valid_q <= 1'b0;
      ptr_q            <= '{id: 4'd0, smallest_rank: 16'hFFFF,
                            smallest_send_time: 16'hFFFF, full: 1'b0, num: 3'd0};
      for (int i = 0; i < N; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      latch_q          <= latch_d;
      pop_elem_q       <= pop_elem_d;
      pop_elem_valid_q <= pop_elem_valid_d;
      ptr_q            <= ptr_d;
      entries_q        <= entries_d;
    end
  end

  assign pop_elem       = pop_elem_q;
  assign pop_elem_valid = pop_elem_valid_q;
  assign ptr_out        = ptr_q;

endmodule

// File: tb/tb_sublist_sorted_store.sv
// Scoreboard bench for sublist_sorted_store: a queue-based sorted-list model predicts
// pops, handshake readiness and the lagged pointer summary.
module tb_sublist_sorted_store;
  import vertigo_datatypes::*;

  localparam int N = 8;

  logic          clk, rst;
  logic [3:0]    sublist_id;
  logic          ins_valid, ins_ready, pop_valid, pop_ready, pop_elem_valid;
  SublistElement ins_elem, pop_elem;
  PointerElement ptr_out;

  sublist_sorted_store dut (
    .clk(clk), .rst(rst), .sublist_id(sublist_id),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_elem(ins_elem),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_elem(pop_elem),
    .pop_elem_valid(pop_elem_valid), .ptr_out(ptr_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  // Reference model: sorted list, one pending insert, expected pop stream.
  SublistElement q[$];
  SublistElement sb[$];
  SublistElement pend_elem, last_pop;
  logic          pending;
  logic          exp_valid;
  PointerElement exp_ptr;
  int            ins_acc_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic PointerElement summary();
    PointerElement p;
    p.id                 = sublist_id;
    p.smallest_rank      = (q.size() > 0) ? q[0].rank : 16'hFFFF;
    p.smallest_send_time = 16'hFFFF;
    foreach (q[i]) if (q[i].send_time < p.smallest_send_time) p.smallest_send_time = q[i].send_time;
    p.full = (q.size() == N);
    p.num  = 3'(q.size());
    return p;
  endfunction

  function automatic void model_insert(input SublistElement e);
    int idx = 0;
    while (idx < q.size() && q[idx].rank <= e.rank) idx++;
    q.insert(idx, e);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      sb.delete();
      pending   = 1'b0;
      exp_valid = 1'b0;
      last_pop  = '0;
      exp_ptr   = '{id: 4'd0, smallest_rank: 16'hFFFF, smallest_send_time: 16'hFFFF,
                    full: 1'b0, num: 3'd0};
    end else begin
      exp_ptr   = summary();
      exp_valid = 1'b0;
      if (pending) begin
        model_insert(pend_elem);
        pending = 1'b0;
      end else if (pop_valid && q.size() != 0) begin
        sb.push_back(q.pop_front());
        exp_valid = 1'b1;
      end else if (ins_valid && !pop_valid && q.size() != N) begin
        pend_elem = ins_elem;
        pending   = 1'b1;
        ins_acc_cnt++;
      end
    end
  end

  // Monitor: samples on the falling edge, inputs change 2 time units later.
  always @(negedge clk) begin
    SublistElement e;
    chk("ptr_out", 64'(ptr_out), 64'(exp_ptr));
    chk("pop_ready", 64'(pop_ready), 64'(!pending && q.size() != 0));
    chk("ins_ready", 64'(ins_ready), 64'(!pending && q.size() != N && !pop_valid));
    chk("pop_elem_valid", 64'(pop_elem_valid), 64'(exp_valid));
    if (pop_elem_valid) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", 64'(pop_elem), 64'h0);
      end else begin
        e = sb.pop_front();
        chk("pop_elem", 64'(pop_elem), 64'(e));
        last_pop = e;
      end
    end else begin
      chk("pop_elem_hold", 64'(pop_elem), 64'(last_pop));
    end
  end

  function automatic SublistElement mk(input int id, input int rank, input int st);
    SublistElement e;
    e.id = 6'(id);
    e.rank = 16'(rank);
    e.send_time = 16'(st);
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic ins(input SublistElement e);
    int start = ins_acc_cnt;
    int n = 0;
    ins_elem  = e;
    ins_valid = 1'b1;
    while (ins_acc_cnt == start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ins_timeout", 64'(ins_acc_cnt == start), 64'h0);
    #2;
    ins_valid = 1'b0;
  endtask

  task automatic pops(input int n);
    pop_valid = 1'b1;
    step(n);
    pop_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sublist_id = 4'd5;
    ins_valid = 1'b0;
    pop_valid = 1'b0;
    ins_elem = '0;
    step(2);
    rst = 1'b0;
    step(2);

    // Reset mid-insert: the latched element must vanish.
    ins(mk(9, 3, 3));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);

    ins(mk(1, 30, 100)); ins(mk(2, 10, 100)); ins(mk(3, 20, 100));
    step(2);
    pops(3);
    step(2);

    ins(mk(4, 7, 1)); ins(mk(5, 7, 2)); ins(mk(6, 7, 3));
    step(1);
    pops(3);
    step(2);

    for (int i = 0; i < N; i++) ins(mk(10 + i, 40 - i, 500 + i));
    step(2);
    ins_elem  = mk(30, 1, 1);
    ins_valid = 1'b1;
    step(3);
    pop_valid = 1'b1;
    step(1);
    pop_valid = 1'b0;
    step(4);
    ins_valid = 1'b0;
    step(1);
    pops(N);
    step(2);

    ins(mk(40, 1, 50)); ins(mk(41, 9, 20)); ins(mk(42, 5, 35));
    step(2);
    pops(2);
    step(2);
    pops(1);
    step(2);

    ins(mk(50, 4, 4)); ins(mk(51, 2, 2));
    step(1);
    ins_elem  = mk(52, 3, 3);
    ins_valid = 1'b1;
    pop_valid = 1'b1;
    step(1);
    pop_valid = 1'b0;
    step(3);
    ins_valid = 1'b0;
    step(1);
    pops(3);
    step(2);

    for (int c = 0; c < 1500; c++) begin
      ins_elem  = mk($urandom_range(0, 63), $urandom_range(0, 20), $urandom_range(0, 65535));
      ins_valid = ($urandom_range(0, 2) != 0);
      pop_valid = ($urandom_range(0, 2) == 0);
      rst       = (c == 700);
      step(1);
    end
    rst = 1'b0;
    ins_valid = 1'b0;
    pops(12);
    step(3);

    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
